// File: rtl/button_event_gen.sv
// button_event_gen
//   Debounces a raw active-low pushbutton and turns it into a held level plus
//   press, auto-repeat and release strobes.
//
//   Ports
//     clk           in   system clock
//     rst_n         in   asynchronous active-low reset
//     en            in   synchronous channel enable (0 parks the FSM in IDLE)
//     butt_n        in   raw pushbutton, asynchronous, active-low
//     pressed       out  debounced level, 1 while the button is held
//     press_pulse   out  one-cycle strobe when a press is accepted
//     repeat_pulse  out  one-cycle strobe per auto-repeat while held
//     release_pulse out  one-cycle strobe when a release is accepted
//     long_press    out  1 from the first auto-repeat until the release
module button_event_gen #(
  parameter int DEBOUNCE_CYC = 1_000_000,
  parameter int HOLD_CYC     = 25_000_000,
  parameter int REPEAT_CYC   = 6_250_000,
  parameter int CNTW         = 26
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic butt_n,
  output logic pressed,
  output logic press_pulse,
  output logic repeat_pulse,
  output logic release_pulse,
  output logic long_press
);

  localparam logic [CNTW-1:0] DEB_C  = CNTW'(DEBOUNCE_CYC);
  localparam logic [CNTW-1:0] HOLD_C = CNTW'(HOLD_CYC);
  localparam logic [CNTW-1:0] REP_C  = CNTW'(REPEAT_CYC);
  localparam logic [CNTW-1:0] ONE_C  = CNTW'(1);

  typedef enum logic [2:0] {
    IDLE,
    DB_PRESS,
    HELD,
    REPEAT,
    DB_RELEASE
  } state_t;

  state_t          state_q, state_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            sync1_q, sync1_d;
  logic            sync2_q, sync2_d;
  logic            pressed_q, pressed_d;
  logic            press_pulse_q, press_pulse_d;
  logic            repeat_pulse_q, repeat_pulse_d;
  logic            release_pulse_q, release_pulse_d;
  logic            long_press_q, long_press_d;
  logic            butt_s;
  logic [CNTW-1:0] cnt_inc;

  // Synchronizer resets to "released" (butt_n high) so a button held across
  // reset must be seen through the full debounce again.
  always_comb begin
    sync1_d = butt_n;
    sync2_d = sync1_q;
  end

  assign butt_s  = ~sync2_q;
  assign cnt_inc = cnt_q + ONE_C;

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    pressed_d       = pressed_q;
    long_press_d    = long_press_q;
    press_pulse_d   = 1'b0;
    repeat_pulse_d  = 1'b0;
    release_pulse_d = 1'b0;

    if (!en) begin
      // Disable silently drops everything: no release strobe is generated.
      state_d      = IDLE;
      cnt_d        = '0;
      pressed_d    = 1'b0;
      long_press_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (butt_s) begin
            state_d = DB_PRESS;
            cnt_d   = ONE_C;
          end
        end
        DB_PRESS: begin
          if (!butt_s) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else if (cnt_q == DEB_C) begin
            state_d       = HELD;
            cnt_d         = ONE_C;
            pressed_d     = 1'b1;
            press_pulse_d = 1'b1;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        HELD: begin
          if (!butt_s) begin
            state_d = DB_RELEASE;
            cnt_d   = ONE_C;
          end else if (cnt_q == HOLD_C) begin
            state_d        = REPEAT;
            cnt_d          = ONE_C;
            long_press_d   = 1'b1;
            repeat_pulse_d = 1'b1;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        REPEAT: begin
          if (!butt_s) begin
            state_d = DB_RELEASE;
            cnt_d   = ONE_C;
          end else if (cnt_q == REP_C) begin
            cnt_d          = ONE_C;
            repeat_pulse_d = 1'b1;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        DB_RELEASE: begin
          if (butt_s) begin
            // Release bounce: resume the interval from scratch, no strobe.
            state_d = long_press_q ? REPEAT : HELD;
            cnt_d   = ONE_C;
          end else if (cnt_q == DEB_C) begin
            state_d         = IDLE;
            cnt_d           = '0;
            pressed_d       = 1'b0;
            long_press_d    = 1'b0;
            release_pulse_d = 1'b1;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        default: begin
          state_d      = IDLE;
          cnt_d        = '0;
          pressed_d    = 1'b0;
          long_press_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q         <= 1'b1;
      sync2_q         <= 1'b1;
      state_q         <= IDLE;
      cnt_q           <= '0;
      pressed_q       <= 1'b0;
      press_pulse_q   <= 1'b0;
      repeat_pulse_q  <= 1'b0;
      release_pulse_q <= 1'b0;
      long_press_q    <= 1'b0;
    end else begin
      sync1_q         <= sync1_d;
      sync2_q         <= sync2_d;
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      pressed_q       <= pressed_d;
      press_pulse_q   <= press_pulse_d;
      repeat_pulse_q  <= repeat_pulse_d;
      release_pulse_q <= release_pulse_d;
      long_press_q    <= long_press_d;
    end
  end

  assign pressed       = pressed_q;
  assign press_pulse   = press_pulse_q;
  assign repeat_pulse  = repeat_pulse_q;
  assign release_pulse = release_pulse_q;
  assign long_press    = long_press_q;

endmodule

// File: tb/tb_button_event_gen.sv
// tb_button_event_gen
//   Directed bench for button_event_gen with DEBOUNCE_CYC=4, HOLD_CYC=20,
//   REPEAT_CYC=5. Edge E0 is the first clock edge that samples a new butt_n
//   level (or the first edge after reset release).
module tb_button_event_gen;

  logic clk = 1'b0;
  logic rst_n;
  logic en;
  logic butt_n;
  logic pressed, press_pulse, repeat_pulse, release_pulse, long_press;
  logic [4:0] outs;

  int n_checks = 0;
  int n_pass   = 0;
  int n_press  = 0;
  int n_rep    = 0;
  int n_rel    = 0;
  bit armed    = 1'b0;

  button_event_gen #(
    .DEBOUNCE_CYC(4),
    .HOLD_CYC    (20),
    .REPEAT_CYC  (5),
    .CNTW        (26)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .butt_n       (butt_n),
    .pressed      (pressed),
    .press_pulse  (press_pulse),
    .repeat_pulse (repeat_pulse),
    .release_pulse(release_pulse),
    .long_press   (long_press)
  );

  always #5 clk = ~clk;

  assign outs = {pressed, press_pulse, repeat_pulse, release_pulse, long_press};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges, then settle just past the following falling edge.
  task automatic wait_n(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  // Pulse counters and strobe exclusivity, observed on the falling edge.
  always @(negedge clk) begin
    if (armed && rst_n === 1'b1) begin
      if (press_pulse)   n_press++;
      if (repeat_pulse)  n_rep++;
      if (release_pulse) n_rel++;
      chk("strobe_excl", 32'($onehot0({press_pulse, repeat_pulse, release_pulse})), 32'd1);
    end
  end

  initial begin
    rst_n  = 1'b1;
    en     = 1'b1;
    butt_n = 1'b1;
    @(negedge clk);
    #2;
    // Async reset with the button already down.
    rst_n  = 1'b0;
    butt_n = 1'b0;
    #1;
    chk("rst_immediate", 32'(outs), 32'd0);
    armed = 1'b1;
    wait_n(3);
    chk("rst_held", 32'(outs), 32'd0);
    rst_n = 1'b1;

    // Clean hold: E0 is the first edge after release of reset.
    wait_n(6);
    chk("press_before_E6", 32'(outs), 32'd0);
    wait_n(1);
    chk("press_E6", 32'(outs), 32'b11000);
    wait_n(1);
    chk("press_pulse_one_cycle", 32'(outs), 32'b10000);
    wait_n(18);
    chk("before_first_repeat_E25", 32'(outs), 32'b10000);
    wait_n(1);
    chk("first_repeat_E26", 32'(outs), 32'b10101);
    wait_n(1);
    chk("repeat_one_cycle_E27", 32'(outs), 32'b10001);
    wait_n(3);
    chk("before_repeat_E30", 32'(outs), 32'b10001);
    wait_n(1);
    chk("repeat_E31", 32'(outs), 32'b10101);
    wait_n(5);
    chk("repeat_E36", 32'(outs), 32'b10101);
    chk("press_count_hold", 32'(n_press), 32'd1);
    chk("repeat_count_hold", 32'(n_rep), 32'd3);

    // Release with a 2-cycle low bounce at R0+2: debounce restarts.
    butt_n = 1'b1;
    wait_n(2);
    butt_n = 1'b0;
    wait_n(2);
    butt_n = 1'b1;
    wait_n(6);
    chk("release_pending_R9", 32'(outs), 32'b10001);
    wait_n(1);
    chk("release_R10", 32'(outs), 32'b00010);
    wait_n(1);
    chk("release_one_cycle", 32'(outs), 32'd0);
    chk("press_count_rel", 32'(n_press), 32'd1);
    chk("repeat_count_rel", 32'(n_rep), 32'd3);
    chk("release_count_rel", 32'(n_rel), 32'd1);

    // Glitch: three low samples only.
    butt_n = 1'b0;
    wait_n(3);
    butt_n = 1'b1;
    wait_n(10);
    chk("glitch_outs", 32'(outs), 32'd0);
    chk("glitch_press_count", 32'(n_press), 32'd1);

    // Fresh press from IDLE, then reset two cycles after the first repeat.
    butt_n = 1'b0;
    wait_n(6);
    chk("repress_before_E6", 32'(outs), 32'd0);
    wait_n(1);
    chk("repress_E6", 32'(outs), 32'b11000);
    wait_n(20);
    chk("repress_repeat_E26", 32'(outs), 32'b10101);
    wait_n(2);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_repeat_outs", 32'(outs), 32'd0);
    wait_n(2);
    chk("rst_mid_repeat_no_release", 32'(n_rel), 32'd1);
    rst_n = 1'b1;
    wait_n(6);
    chk("post_rst_before_E6", 32'(outs), 32'd0);
    wait_n(1);
    chk("post_rst_press_E6", 32'(outs), 32'b11000);
    chk("post_rst_press_count", 32'(n_press), 32'd3);

    // Enable dropped during HELD, then raised with the button still down.
    wait_n(3);
    en = 1'b0;
    wait_n(1);
    chk("en_off_next_edge", 32'(outs), 32'd0);
    wait_n(5);
    chk("en_off_idle", 32'(outs), 32'd0);
    chk("en_off_no_release", 32'(n_rel), 32'd1);
    en = 1'b1;
    wait_n(4);
    chk("en_on_debouncing", 32'(outs), 32'd0);
    wait_n(1);
    chk("en_on_press", 32'(outs), 32'b11000);
    chk("en_on_press_count", 32'(n_press), 32'd4);

    armed = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
